// File: rtl/masked_sram_pkg.sv
// Shared types and helpers for the masked 1R1W SRAM.
package masked_sram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } sram_state_t;

  // Upper bound on word width accepted by expand_mask; callers truncate the result.
  localparam int MAX_DATA_W = 1024;
  localparam int MAX_IDX_W  = $clog2(MAX_DATA_W);

  function automatic logic [MAX_DATA_W-1:0] expand_mask(
    input logic [MAX_DATA_W-1:0] mask,
    input int                    gran
  );
    logic [MAX_DATA_W-1:0] bits;
    bits = '0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      bits[MAX_IDX_W'(i)] = mask[MAX_IDX_W'(i / gran)];
    end
    return bits;
  endfunction

endpackage

// File: rtl/masked_sram_init_ctrl.sv
// Post-reset clear sweep: walks every word address once, then reports ready.
//   state | meaning
//   INIT  | sweeping, sweep_we high, counter advances each cycle
//   READY | sweep finished, user ports enabled
module masked_sram_init_ctrl
  import masked_sram_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] sweep_addr,
  output logic              sweep_we,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  sram_state_t       state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Counter parks on the last address instead of wrapping.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sweep_we  = 1'b0;
    init_done = 1'b0;
    case (state)
      INIT: begin
        sweep_we = 1'b1;
        if (cnt == LAST) state_nxt = READY;
        else             cnt_nxt   = cnt + ADDR_W'(1);
      end
      READY: init_done = 1'b1;
    endcase
  end

  assign sweep_addr = cnt;

endmodule

// File: rtl/masked_sram_1r1w.sv
// Masked-write 1R1W SRAM with post-reset clear sweep and one-cycle registered read.
// Define MASKED_SRAM_BYPASS_EN to forward same-address write data into the read.
module masked_sram_1r1w
  import masked_sram_pkg::*;
#(
  parameter int  DATA_W    = 64,
  parameter int  DEPTH     = 512,
  parameter int  MASK_GRAN = 8,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int MASK_SEG  = DATA_W / MASK_GRAN
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                W0_en,
  input  logic [ADDR_W-1:0]   W0_addr,
  input  logic [MASK_SEG-1:0] W0_mask,
  input  logic [DATA_W-1:0]   W0_data,
  input  logic                R0_en,
  input  logic [ADDR_W-1:0]   R0_addr,
  output logic [DATA_W-1:0]   R0_data,
  output logic                R0_valid,
  output logic                init_done
);

  if ((DATA_W % MASK_GRAN) != 0 || DEPTH < 2 || DATA_W > MAX_DATA_W) begin : g_param_check
    $error("masked_sram_1r1w: DATA_W must be a multiple of MASK_GRAN and DEPTH >= 2");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] sweep_addr;
  logic              sweep_we;
  logic              w_ok, r_ok, w_fire, r_fire;
  logic [DATA_W-1:0] wmask, w_merged, rd_word;

  masked_sram_init_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_init_ctrl (
    .clock      (clock),
    .reset      (reset),
    .sweep_addr (sweep_addr),
    .sweep_we   (sweep_we),
    .init_done  (init_done)
  );

  assign w_ok   = {1'b0, W0_addr} < (ADDR_W + 1)'(DEPTH);
  assign r_ok   = {1'b0, R0_addr} < (ADDR_W + 1)'(DEPTH);
  assign w_fire = init_done & W0_en & w_ok & ~reset;
  assign r_fire = init_done & R0_en & ~reset;

  assign wmask    = DATA_W'(expand_mask(MAX_DATA_W'(W0_mask), MASK_GRAN));
  assign w_merged = (mem[W0_addr] & ~wmask) | (W0_data & wmask);

  always_comb begin
    rd_word = '0;
    if (r_ok) begin
      rd_word = mem[R0_addr];
`ifdef MASKED_SRAM_BYPASS_EN
      if (w_fire && (W0_addr == R0_addr)) rd_word = (rd_word & ~wmask) | (W0_data & wmask);
`endif
    end
  end

  // Array has no reset; only the sweep clears it.
  always_ff @(posedge clock) begin
    if (sweep_we)    mem[sweep_addr] <= '0;
    else if (w_fire) mem[W0_addr]    <= w_merged;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      R0_data  <= '0;
      R0_valid <= 1'b0;
    end else begin
      R0_valid <= r_fire;
      if (r_fire) R0_data <= rd_word;
    end
  end

endmodule

// File: tb/tb_masked_sram_1r1w.sv
// Directed scoreboard bench for masked_sram_1r1w (DATA_W=64, DEPTH=16, MASK_GRAN=8).
module tb_masked_sram_1r1w;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        W0_en = 1'b0;
  logic [3:0]  W0_addr = '0;
  logic [7:0]  W0_mask = '0;
  logic [63:0] W0_data = '0;
  logic        R0_en = 1'b0;
  logic [3:0]  R0_addr = '0;
  logic [63:0] R0_data;
  logic        R0_valid;
  logic        init_done;

  masked_sram_1r1w #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MASK_GRAN(8)) dut (
    .clock(clock), .reset(reset),
    .W0_en(W0_en), .W0_addr(W0_addr), .W0_mask(W0_mask), .W0_data(W0_data),
    .R0_en(R0_en), .R0_addr(R0_addr), .R0_data(R0_data), .R0_valid(R0_valid),
    .init_done(init_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  logic [63:0] mdl [DEPTH];
  logic [63:0] exp_last = '0;
  logic        ready = 1'b0;
  int          init_cnt = 0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always @(posedge clock) cyc++;

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [7:0] m,
                                        input logic [63:0] wd);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (m[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      n_cmp++;
      assert (R0_valid === 1'b1)
        else begin n_err++; $error("FAIL rd_valid cyc=%0d observed=%b expected=1", cyc, R0_valid); end
      n_cmp++;
      assert (R0_data === e.data)
        else begin n_err++; $error("FAIL rd_data cyc=%0d observed=%h expected=%h", cyc, R0_data, e.data); end
      exp_last = e.data;
    end else begin
      n_cmp++;
      assert (R0_valid === 1'b0)
        else begin n_err++; $error("FAIL idle_valid cyc=%0d observed=%b expected=0", cyc, R0_valid); end
      n_cmp++;
      assert (R0_data === exp_last)
        else begin n_err++; $error("FAIL hold_data cyc=%0d observed=%h expected=%h", cyc, R0_data, exp_last); end
    end
  end

  task automatic do_cycle();
    @(posedge clock);
    #1;
    if (reset) begin
      ready    = 1'b0;
      init_cnt = 0;
      exp_last = '0;
    end else if (!ready) begin
      init_cnt++;
      if (init_cnt == DEPTH) begin
        ready = 1'b1;
        foreach (mdl[i]) mdl[i] = '0;
      end
    end
    n_cmp++;
    assert (init_done === ready)
      else begin n_err++; $error("FAIL init_done cyc=%0d observed=%b expected=%b", cyc, init_done, ready); end
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [7:0] wm,
                       input logic [63:0] wd, input logic re, input logic [3:0] ra);
    exp_t        e;
    logic [63:0] d;
    W0_en = we; W0_addr = wa; W0_mask = wm; W0_data = wd;
    R0_en = re; R0_addr = ra;
    if (ready && !reset) begin
      if (re) begin
        d = mdl[ra];
`ifdef MASKED_SRAM_BYPASS_EN
        if (we && wa == ra) d = merge(mdl[ra], wm, wd);
`endif
        e.data = d;
        e.due  = cyc + 1;
        sbq.push_back(e);
      end
      if (we) mdl[wa] = merge(mdl[wa], wm, wd);
    end
    do_cycle();
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 8'h00, 64'd0, 1'b0, 4'd0);
  endtask

  initial begin
    // Reset and sweep with both ports hammered during INIT.
    reset = 1'b1;
    repeat (3) idle();
    reset = 1'b0;
    for (int k = 0; k < DEPTH; k++)
      drive(1'b1, 4'($urandom_range(15)), 8'hFF, {$urandom, $urandom}, 1'b1, 4'($urandom_range(15)));

    // First ready cycle read, then every address must be zero.
    drive(1'b0, 4'd0, 8'h00, 64'd0, 1'b1, 4'd5);
    for (int a = 0; a < DEPTH; a++) drive(1'b0, 4'd0, 8'h00, 64'd0, 1'b1, 4'(a));
    idle();

    // Masked partial update and empty mask.
    drive(1'b1, 4'd3, 8'hFF, 64'h1122334455667788, 1'b0, 4'd0);
    drive(1'b1, 4'd3, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 1'b0, 4'd0);
    drive(1'b0, 4'd0, 8'h00, 64'd0, 1'b1, 4'd3);
    drive(1'b1, 4'd3, 8'h00, 64'hDEADBEEFCAFEF00D, 1'b0, 4'd0);
    drive(1'b0, 4'd0, 8'h00, 64'd0, 1'b1, 4'd3);

    // Same-address collision, then read back the merged word.
    drive(1'b1, 4'd3, 8'h01, 64'hFFFFFFFFFFFFFFFF, 1'b1, 4'd3);
    drive(1'b0, 4'd0, 8'h00, 64'd0, 1'b1, 4'd3);

    // Read and write to different addresses in the same cycle.
    drive(1'b1, 4'd7, 8'hA5, 64'h0123456789ABCDEF, 1'b1, 4'd3);
    drive(1'b0, 4'd0, 8'h00, 64'd0, 1'b1, 4'd7);

    // Pattern fill and 16 back-to-back reads.
    for (int a = 0; a < DEPTH; a++)
      drive(1'b1, 4'(a), 8'hFF, {8{4'(a), 4'(15 - a)}}, 1'b0, 4'd0);
    for (int a = 0; a < DEPTH; a++) drive(1'b0, 4'd0, 8'h00, 64'd0, 1'b1, 4'(a));

    // Random mixed traffic.
    for (int k = 0; k < 40; k++)
      drive(1'($urandom_range(1)), 4'($urandom_range(15)), 8'($urandom), {$urandom, $urandom},
            1'($urandom_range(1)), 4'($urandom_range(15)));
    drive(1'b1, 4'd12, 8'hFF, 64'h5A5A5A5A12121212, 1'b1, 4'd12);
    idle();

    // Reset mid-operation with a read and write in flight, then again mid-sweep.
    reset = 1'b1;
    drive(1'b1, 4'd12, 8'hFF, 64'hFFFF0000FFFF0000, 1'b1, 4'd12);
    reset = 1'b0;
    repeat (7) idle();
    reset = 1'b1;
    drive(1'b0, 4'd0, 8'h00, 64'd0, 1'b1, 4'd12);
    reset = 1'b0;
    repeat (DEPTH) idle();
    drive(1'b0, 4'd0, 8'h00, 64'd0, 1'b1, 4'd12);
    drive(1'b0, 4'd0, 8'h00, 64'd0, 1'b1, 4'd3);
    repeat (3) idle();

    n_cmp++;
    assert (sbq.size() == 0)
      else begin n_err++; $error("FAIL drain observed=%0d pending expected=0", sbq.size()); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
